// File: rtl/cam_init_sequencer.sv
// Camera register-initialisation sequencer: walks a {reg, data} table after a
// power-up delay and issues one I2C write request per entry, with delay/end markers.
module cam_init_sequencer #(
  parameter int unsigned NUM_REGS       = 16,
  parameter logic [7:0]  SLAVE_ADDR     = 8'h10,
  parameter int unsigned XFER_CYCLES    = 40,
  parameter int unsigned POWERUP_CYCLES = 1000,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clk400kHz,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  tbl_addr,
  input  logic [23:0] tbl_data,
  output logic        send_data,
  output logic [15:0] register_in,
  output logic [7:0]  datain,
  output logic [7:0]  slave_addr,
  output logic        busy,
  output logic        done,
  output logic [7:0]  writes_issued
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_POWERUP = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_LATCH   = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;
  localparam logic [2:0] S_DELAY   = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [15:0] XFER_LOAD = 16'(XFER_CYCLES - 1);
  localparam logic [15:0] PWR_LOAD  = 16'(POWERUP_CYCLES - 1);
  localparam logic [7:0]  LAST_IDX  = 8'(NUM_REGS);
  localparam logic [15:0] REG_END   = 16'hFFFE;
  localparam logic [15:0] REG_DELAY = 16'hFFFF;

  logic [2:0]  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        start_q, start_d;
  logic        auto_q, auto_d;
  logic [7:0]  tbl_addr_q, tbl_addr_d;
  logic        send_q, send_d;
  logic [15:0] reg_q, reg_d;
  logic [7:0]  dat_q, dat_d;
  logic [7:0]  writes_q, writes_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        start_evt;
  logic [15:0] tbl_reg;
  logic [7:0]  tbl_val;

  assign tbl_reg = tbl_data[23:8];
  assign tbl_val = tbl_data[7:0];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tbl_addr_d = tbl_addr_q;
    send_d     = 1'b0;
    reg_d      = reg_q;
    dat_d      = dat_q;
    writes_d   = writes_q;
    start_d    = start;
    auto_d     = 1'b0;
    start_evt  = (start & ~start_q) | auto_q;

    case (state_q)
      S_IDLE: begin
        if (start_evt) begin
          state_d = S_POWERUP;
          cnt_d   = PWR_LOAD;
        end
      end
      S_POWERUP: begin
        if (cnt_q == '0) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_FETCH: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          tbl_addr_d = idx_q;
          state_d    = S_LATCH;
        end
      end
      S_LATCH: begin
        if (tbl_reg == REG_END) begin
          state_d = S_DONE;
        end else if (tbl_reg == REG_DELAY) begin
          if (tbl_val == '0) begin
            idx_d   = idx_q + 8'd1;
            state_d = S_FETCH;
          end else begin
            // Loaded one short so DELAY lasts exactly data*256 cycles.
            cnt_d   = {tbl_val, 8'h00} - 16'd1;
            state_d = S_DELAY;
          end
        end else begin
          reg_d   = tbl_reg;
          dat_d   = tbl_val;
          send_d  = 1'b1;
          cnt_d   = XFER_LOAD;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        // Transaction counter runs from the send_data rise; its first value marks pulse cycle one.
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == XFER_LOAD) begin
          send_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          idx_d   = idx_q + 8'd1;
          state_d = S_FETCH;
          if (writes_q != 8'hFF) begin
            writes_d = writes_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          idx_d   = idx_q + 8'd1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DONE: begin
        if (start_evt) begin
          idx_d    = '0;
          writes_d = '0;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk400kHz or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      auto_q     <= AUTO_START;
      tbl_addr_q <= '0;
      send_q     <= 1'b0;
      reg_q      <= '0;
      dat_q      <= '0;
      writes_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      auto_q     <= auto_d;
      tbl_addr_q <= tbl_addr_d;
      send_q     <= send_d;
      reg_q      <= reg_d;
      dat_q      <= dat_d;
      writes_q   <= writes_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tbl_addr      = tbl_addr_q;
  assign send_data     = send_q;
  assign register_in   = reg_q;
  assign datain        = dat_q;
  assign slave_addr    = SLAVE_ADDR;
  assign busy          = busy_q;
  assign done          = done_q;
  assign writes_issued = writes_q;

endmodule
